// File: rtl/spi_minion_rx_tx.sv
// SPI mode-0 minion front-end: oversamples the pad pins in the clk domain and
// converts frames into val/rdy receive and send streams, with packet parity.
module spi_minion_rx_tx #(
    parameter int BIT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 cs,
    input  logic                 sclk,
    input  logic                 mosi,
    output logic                 miso,
    output logic [BIT_WIDTH-1:0] recv_msg,
    output logic                 recv_val,
    input  logic                 recv_rdy,
    input  logic [BIT_WIDTH-1:0] send_msg,
    input  logic                 send_val,
    output logic                 send_rdy,
    output logic                 parity,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int CW = $clog2(BIT_WIDTH + 2);
    localparam logic [CW-1:0] CNT_FULL = CW'(BIT_WIDTH);
    localparam logic [CW-1:0] CNT_SAT  = CW'(BIT_WIDTH + 1);

    typedef enum logic [0:0] {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    function automatic logic parity_of(input logic [BIT_WIDTH-1:0] word);
        return ^word;
    endfunction

    logic [1:0]           cs_sync_r, sclk_sync_r, mosi_sync_r;
    logic                 cs_hist_r, sclk_hist_r, mosi_hist_r;
    logic                 cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    state_t               state_r, state_next_s;
    logic [BIT_WIDTH-1:0] shreg_r;
    logic [CW-1:0]        count_r;
    logic                 rx_bit_r;
    logic [BIT_WIDTH-1:0] recv_msg_r;
    logic                 recv_val_r, parity_r, frame_err_r, overrun_r;
    logic                 send_rdy_s, miso_s, frame_done_s, recv_hold_s;

    // Pad synchronizers; cs resets high so a low pad after reset reads as a fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            cs_sync_r   <= 2'b11;
            cs_hist_r   <= 1'b1;
            sclk_sync_r <= 2'b00;
            sclk_hist_r <= 1'b0;
            mosi_sync_r <= 2'b00;
            mosi_hist_r <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[0], cs};
            cs_hist_r   <= cs_sync_r[1];
            sclk_sync_r <= {sclk_sync_r[0], sclk};
            sclk_hist_r <= sclk_sync_r[1];
            mosi_sync_r <= {mosi_sync_r[0], mosi};
            mosi_hist_r <= mosi_sync_r[1];
        end
    end

    assign cs_fall_s   =  cs_hist_r   & ~cs_sync_r[1];
    assign cs_rise_s   = ~cs_hist_r   &  cs_sync_r[1];
    assign sclk_rise_s = ~sclk_hist_r &  sclk_sync_r[1];
    assign sclk_fall_s =  sclk_hist_r & ~sclk_sync_r[1];

    // FSM state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Next-state, send handshake strobe, miso and frame-end qualifiers.
    always_comb begin
        state_next_s = state_r;
        send_rdy_s   = 1'b0;
        miso_s       = 1'b0;
        frame_done_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s && !reset) begin
                    state_next_s = ACTIVE;
                    send_rdy_s   = 1'b1;
                end else begin
                    state_next_s = IDLE;
                end
            end
            ACTIVE: begin
                miso_s = shreg_r[BIT_WIDTH-1];
                if (cs_rise_s) begin
                    state_next_s = IDLE;
                    frame_done_s = 1'b1;
                end else begin
                    state_next_s = ACTIVE;
                end
            end
            default: begin
                state_next_s = IDLE;
            end
        endcase
        // A word being consumed this cycle frees the slot for a new frame.
        recv_hold_s = recv_val_r & ~recv_rdy;
    end

    // Shift register and bit counter; mosi bit captured on rise, shifted on fall.
    always_ff @(posedge clk) begin
        if (reset) begin
            shreg_r  <= {BIT_WIDTH{1'b0}};
            count_r  <= {CW{1'b0}};
            rx_bit_r <= 1'b0;
        end else if (send_rdy_s) begin
            shreg_r <= send_val ? send_msg : {BIT_WIDTH{1'b0}};
            count_r <= {CW{1'b0}};
        end else if (state_r == ACTIVE) begin
            if (sclk_rise_s) begin
                rx_bit_r <= mosi_hist_r;
                if (count_r != CNT_SAT) begin
                    count_r <= count_r + CW'(1);
                end
            end
            if (sclk_fall_s) begin
                shreg_r <= {shreg_r[BIT_WIDTH-2:0], rx_bit_r};
            end
        end
    end

    // Receive stream, parity and error pulses at frame end.
    always_ff @(posedge clk) begin
        if (reset) begin
            recv_msg_r  <= {BIT_WIDTH{1'b0}};
            recv_val_r  <= 1'b0;
            parity_r    <= 1'b0;
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
        end else begin
            frame_err_r <= 1'b0;
            overrun_r   <= 1'b0;
            if (recv_val_r && recv_rdy) begin
                recv_val_r <= 1'b0;
            end
            if (frame_done_s) begin
                if (count_r != CNT_FULL) begin
                    frame_err_r <= 1'b1;
                end else if (recv_hold_s) begin
                    overrun_r <= 1'b1;
                end else begin
                    recv_msg_r <= shreg_r;
                    parity_r   <= parity_of(shreg_r);
                    recv_val_r <= 1'b1;
                end
            end
        end
    end

    assign miso      = miso_s;
    assign send_rdy  = send_rdy_s;
    assign recv_msg  = recv_msg_r;
    assign recv_val  = recv_val_r;
    assign parity    = parity_r;
    assign frame_err = frame_err_r;
    assign overrun   = overrun_r;

endmodule

// File: tb/tb_spi_minion_rx_tx.sv
// Scoreboard bench for spi_minion_rx_tx: a bit-banged SPI master drives frames,
// expected received words are queued and checked by an independent monitor.
module tb_spi_minion_rx_tx;
    localparam int BW = 32;

    logic          clk = 1'b0;
    logic          reset, cs, sclk, mosi, miso;
    logic [BW-1:0] recv_msg, send_msg;
    logic          recv_val, recv_rdy, send_val, send_rdy, parity, frame_err, overrun;

    int chk_cnt = 0;
    int pass_cnt = 0;
    int n_ferr = 0;
    int n_ovr = 0;
    int n_srdy = 0;
    logic [BW-1:0] exp_q[$];

    always #5 clk = ~clk;

    spi_minion_rx_tx #(.BIT_WIDTH(BW)) dut (
        .clk(clk), .reset(reset), .cs(cs), .sclk(sclk), .mosi(mosi), .miso(miso),
        .recv_msg(recv_msg), .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_msg(send_msg), .send_val(send_val), .send_rdy(send_rdy),
        .parity(parity), .frame_err(frame_err), .overrun(overrun)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitor: pulse counters and scoreboard pop on each receive handshake.
    always @(negedge clk) begin : monitor
        logic [BW-1:0] w;
        if (send_rdy)  n_srdy++;
        if (frame_err) n_ferr++;
        if (overrun)   n_ovr++;
        if (recv_val && recv_rdy && !reset) begin
            if (exp_q.size() == 0) begin
                check("recv_unexpected", 64'(recv_msg), 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                w = exp_q.pop_front();
                check("recv_msg", 64'(recv_msg), 64'(w));
                check("parity", 64'(parity), 64'($countones(w) % 2));
            end
        end
    end

    initial begin
        #3ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clock_bits(input logic [63:0] word, input int n, output logic [63:0] got);
        got = 64'd0;
        for (int i = n - 1; i >= 0; i--) begin
            mosi = word[i];
            wait_clk(5);
            got  = {got[62:0], miso};
            sclk = 1'b1;
            wait_clk(5);
            sclk = 1'b0;
        end
    endtask

    task automatic frame_end(input int gap);
        wait_clk(5);
        cs = 1'b1;
        wait_clk(gap);
    endtask

    task automatic run_frame(input logic [63:0] word, input int n, input int gap,
                             output logic [63:0] got);
        cs = 1'b0;
        wait_clk(5);
        clock_bits(word, n, got);
        frame_end(gap);
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) wait_clk(1);
        check(name, 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [63:0] got;
        logic [BW-1:0] w, sm;
        int f0, o0, s0;
        reset = 1'b1; cs = 1'b1; sclk = 1'b0; mosi = 1'b0;
        recv_rdy = 1'b1; send_val = 1'b0; send_msg = {BW{1'b0}};
        wait_clk(3);
        check("rst_recv_val", 64'(recv_val), 64'd0);
        check("rst_recv_msg", 64'(recv_msg), 64'd0);
        check("rst_miso", 64'(miso), 64'd0);
        check("rst_parity", 64'(parity), 64'd0);
        reset = 1'b0;
        wait_clk(3);

        // Basic full-duplex frame.
        f0 = n_ferr; o0 = n_ovr; s0 = n_srdy;
        send_val = 1'b1; send_msg = 32'hA5A5_0F0F;
        exp_q.push_back(32'h1234_5678);
        run_frame(64'h1234_5678, 32, 8, got);
        send_val = 1'b0;
        check("basic_miso", got, 64'hA5A5_0F0F);
        check("basic_send_rdy", 64'(n_srdy - s0), 64'd1);
        drain("basic_drain");
        check("basic_errs", 64'((n_ferr - f0) + (n_ovr - o0)), 64'd0);

        // Overrun while consumer stalls.
        recv_rdy = 1'b0; o0 = n_ovr;
        exp_q.push_back(32'h1);
        run_frame(64'h1, 32, 8, got);
        run_frame(64'h2, 32, 8, got);
        check("ovr_recv_val", 64'(recv_val), 64'd1);
        check("ovr_recv_msg", 64'(recv_msg), 64'h1);
        check("ovr_pulse", 64'(n_ovr - o0), 64'd1);
        recv_rdy = 1'b1;
        wait_clk(1);
        check("ovr_val_drop", 64'(recv_val), 64'd0);
        drain("ovr_drain");

        // Short and long frames, then a clean one.
        f0 = n_ferr;
        run_frame(64'h7FFF_FFFF, 31, 8, got);
        run_frame(64'h1_FFFF_FFFF, 33, 8, got);
        check("len_ferr", 64'(n_ferr - f0), 64'd2);
        exp_q.push_back(32'hFFFF_FFFF);
        run_frame(64'hFFFF_FFFF, 32, 8, got);
        drain("len_drain");

        // No send word available.
        s0 = n_srdy; send_val = 1'b0; send_msg = 32'h5A5A_F00D;
        exp_q.push_back(32'h0BAD_C0DE);
        run_frame(64'h0BAD_C0DE, 32, 8, got);
        check("nosend_miso", got, 64'd0);
        check("nosend_send_rdy", 64'(n_srdy - s0), 64'd1);
        drain("nosend_drain");

        // Reset in the middle of a frame.
        f0 = n_ferr; send_val = 1'b1; send_msg = 32'hFFFF_0000;
        cs = 1'b0;
        wait_clk(5);
        clock_bits(64'h0000_ABCD, 16, got);
        reset = 1'b1;
        send_val = 1'b0;
        wait_clk(3);
        check("mid_rst_recv_msg", 64'(recv_msg), 64'd0);
        check("mid_rst_outs", 64'({recv_val, parity, miso, send_rdy, frame_err, overrun}), 64'd0);
        reset = 1'b0;
        wait_clk(5);
        clock_bits(64'h0000_1234, 16, got);
        frame_end(8);
        check("mid_rst_ferr", 64'(n_ferr - f0), 64'd1);
        check("mid_rst_no_val", 64'(recv_val), 64'd0);
        exp_q.push_back(32'hDEAD_BEEF);
        run_frame(64'hDEAD_BEEF, 32, 8, got);
        drain("mid_rst_drain");

        // Back-to-back frames with minimum gap.
        o0 = n_ovr;
        exp_q.push_back(32'hCAFE_0001);
        exp_q.push_back(32'hCAFE_0002);
        run_frame(64'hCAFE_0001, 32, 4, got);
        run_frame(64'hCAFE_0002, 32, 4, got);
        drain("b2b_drain");
        check("b2b_no_ovr", 64'(n_ovr - o0), 64'd0);

        // Randomized frames against the reference.
        f0 = n_ferr; o0 = n_ovr;
        for (int k = 0; k < 16; k++) begin
            w  = $urandom;
            sm = $urandom;
            send_val = 1'($urandom_range(0, 1));
            send_msg = sm;
            s0 = n_srdy;
            exp_q.push_back(w);
            run_frame(64'(w), 32, $urandom_range(4, 8), got);
            check("rand_miso", got, send_val ? 64'(sm) : 64'd0);
            check("rand_send_rdy", 64'(n_srdy - s0), 64'd1);
        end
        drain("rand_drain");
        check("rand_errs", 64'((n_ferr - f0) + (n_ovr - o0)), 64'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end
endmodule
